// File: rtl/riscv_fpu_cmpl_buffer.sv
// In-order completion buffer between FPU issue and writeback.
// Optional zero-latency head bypass: define RISCV_FPU_CMPL_BYPASS_EN.
module riscv_fpu_cmpl_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 4,
    parameter int REG_ADDR_WIDTH = 5,
    localparam int TAG_WIDTH     = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd_addr_i,
    output logic [TAG_WIDTH-1:0]      issue_tag_o,
    input  logic                      cmpl_valid_i,
    input  logic [TAG_WIDTH-1:0]      cmpl_tag_i,
    input  logic [DATA_WIDTH-1:0]     cmpl_data_i,
    input  logic                      cmpl_error_i,
    output logic                      cmpl_spurious_o,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]     rsp_data_o,
    output logic                      rsp_error_o,
    output logic [REG_ADDR_WIDTH-1:0] rsp_rd_addr_o,
    output logic [TAG_WIDTH:0]        count_o
);

    localparam int PW = TAG_WIDTH + 1;

    logic [PW-1:0]             head_q, head_d;
    logic [PW-1:0]             tail_q, tail_d;
    logic [DEPTH-1:0]          alloc_q, alloc_d;
    logic [DEPTH-1:0]          done_q, done_d;
    logic [DEPTH-1:0]          err_q, err_d;
    logic [DATA_WIDTH-1:0]     data_q [DEPTH];
    logic [DATA_WIDTH-1:0]     data_d [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] rd_q [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] rd_d [DEPTH];
    logic                      spur_q, spur_d;

    logic [TAG_WIDTH-1:0] head_idx;
    logic [TAG_WIDTH-1:0] tail_idx;
    logic                 full;
    logic                 issue_fire;
    logic                 cmpl_ok;
    logic                 cmpl_store;
    logic                 head_done;
    logic                 retire;
    logic                 rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                 rsp_error;

    assign head_idx   = head_q[TAG_WIDTH-1:0];
    assign tail_idx   = tail_q[TAG_WIDTH-1:0];
    // Same slot index with differing wrap bits means every slot is taken.
    assign full       = (head_idx == tail_idx) &&
                        (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]);
    assign issue_fire = issue_valid_i & ~full;
    assign cmpl_ok    = cmpl_valid_i & alloc_q[cmpl_tag_i] & ~done_q[cmpl_tag_i];
    assign head_done  = alloc_q[head_idx] & done_q[head_idx];

`ifdef RISCV_FPU_CMPL_BYPASS_EN
    logic byp;
    // A fresh result for the head slot is forwarded straight to writeback.
    assign byp        = cmpl_ok & ~flush_i & (cmpl_tag_i == head_idx);
    assign rsp_valid  = head_done | byp;
    assign rsp_data   = byp ? cmpl_data_i : data_q[head_idx];
    assign rsp_error  = byp ? cmpl_error_i : err_q[head_idx];
    // A forwarded result that retires at once never needs to be stored.
    assign cmpl_store = cmpl_ok & ~(byp & rsp_ready_i);
`else
    assign rsp_valid  = head_done;
    assign rsp_data   = data_q[head_idx];
    assign rsp_error  = err_q[head_idx];
    assign cmpl_store = cmpl_ok;
`endif

    assign retire = rsp_valid & rsp_ready_i & ~flush_i;

    assign issue_ready_o   = ~full;
    assign issue_tag_o     = tail_idx;
    assign count_o         = tail_q - head_q;
    assign cmpl_spurious_o = spur_q;
    assign rsp_valid_o     = rsp_valid;
    assign rsp_data_o      = rsp_valid ? rsp_data : '0;
    assign rsp_error_o     = rsp_valid ? rsp_error : 1'b0;
    assign rsp_rd_addr_o   = rsp_valid ? rd_q[head_idx] : '0;

    // Next-state: flush wipes everything, otherwise complete/retire/issue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        err_d   = err_q;
        data_d  = data_q;
        rd_d    = rd_q;
        spur_d  = cmpl_valid_i & ~cmpl_ok & ~flush_i;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            alloc_d = '0;
            done_d  = '0;
        end else begin
            if (cmpl_store) begin
                done_d[cmpl_tag_i] = 1'b1;
                data_d[cmpl_tag_i] = cmpl_data_i;
                err_d[cmpl_tag_i]  = cmpl_error_i;
            end
            if (retire) begin
                alloc_d[head_idx] = 1'b0;
                done_d[head_idx]  = 1'b0;
                head_d            = head_q + PW'(1);
            end
            if (issue_fire) begin
                alloc_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                rd_d[tail_idx]    = issue_rd_addr_i;
                tail_d            = tail_q + PW'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            alloc_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            data_q  <= '{default: '0};
            rd_q    <= '{default: '0};
            spur_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
            spur_q  <= spur_d;
        end
    end

endmodule

// File: tb/tb_riscv_fpu_cmpl_buffer.sv
// Bench for riscv_fpu_cmpl_buffer: queue-based model plus directed tests.
// Build with +define+RISCV_FPU_CMPL_BYPASS_EN to cover the bypass variant.
module tb_riscv_fpu_cmpl_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        iv = 1'b0;
    logic        irdy;
    logic [4:0]  ird = '0;
    logic [1:0]  itag;
    logic        cv = 1'b0;
    logic [1:0]  ctag = '0;
    logic [31:0] cdata = '0;
    logic        cerr = 1'b0;
    logic        spur;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] rdata;
    logic        rerr;
    logic [4:0]  rrd;
    logic [2:0]  count;

    always #5 clk = ~clk;

    riscv_fpu_cmpl_buffer dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .issue_valid_i(iv), .issue_ready_o(irdy),
        .issue_rd_addr_i(ird), .issue_tag_o(itag),
        .cmpl_valid_i(cv), .cmpl_tag_i(ctag), .cmpl_data_i(cdata),
        .cmpl_error_i(cerr), .cmpl_spurious_o(spur),
        .rsp_valid_o(rvalid), .rsp_ready_i(rready), .rsp_data_o(rdata),
        .rsp_error_o(rerr), .rsp_rd_addr_o(rrd), .count_o(count)
    );

    int passed = 0;
    int total = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: ordered list of in-flight operations, oldest first.
    typedef struct {
        logic [4:0]  rd;
        bit          done;
        logic [31:0] data;
        logic        err;
        int          tag;
    } ent_t;

    ent_t mq[$];
    int   ntag = 0;
    bit   m_spur = 0;

    function automatic int find(int tag);
        foreach (mq[i]) if (mq[i].tag == tag) return i;
        return -1;
    endfunction

    function automatic bit m_byp();
`ifdef RISCV_FPU_CMPL_BYPASS_EN
        return cv && !flush && mq.size() > 0 &&
               mq[0].tag == int'(ctag) && !mq[0].done;
`else
        return 0;
`endif
    endfunction

    function automatic bit m_valid();
        return (mq.size() > 0 && mq[0].done) || m_byp();
    endfunction

    bit m_ret, m_ok, m_bp;
    int m_idx, m_sz;

    // Model advances on each clock edge; reset empties it at once.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            ntag = 0;
            m_spur = 0;
        end else if (flush) begin
            mq.delete();
            ntag = 0;
            m_spur = 0;
        end else begin
            m_bp  = m_byp();
            m_ret = m_valid() && rready;
            m_idx = find(int'(ctag));
            m_ok  = cv && m_idx >= 0 && !mq[m_idx].done;
            m_spur = cv && !m_ok;
            if (m_ok && !(m_bp && rready)) begin
                mq[m_idx].done = 1;
                mq[m_idx].data = cdata;
                mq[m_idx].err  = cerr;
            end
            m_sz = mq.size();
            if (m_ret) void'(mq.pop_front());
            if (iv && m_sz < DEPTH) begin
                mq.push_back('{rd: ird, done: 0, data: '0, err: 0, tag: ntag});
                ntag = (ntag + 1) % DEPTH;
            end
        end
    end

    logic [31:0] log_d[$];
    logic [4:0]  log_rd[$];
    int          spur_cnt = 0;
    logic        e_v;
    logic [31:0] e_d;
    logic        e_e;
    logic [4:0]  e_rd;

    // Compare process: every output against the model, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            e_v = m_valid();
            e_d = '0;
            e_e = 1'b0;
            e_rd = '0;
            if (e_v) begin
                e_rd = mq[0].rd;
                if (m_byp()) begin
                    e_d = cdata;
                    e_e = cerr;
                end else begin
                    e_d = mq[0].data;
                    e_e = mq[0].err;
                end
            end
            chk("count", 32'(count), 32'(mq.size()));
            chk("issue_ready", 32'(irdy), 32'(mq.size() < DEPTH));
            chk("issue_tag", 32'(itag), 32'(ntag));
            chk("spurious", 32'(spur), 32'(m_spur));
            chk("rsp_valid", 32'(rvalid), 32'(e_v));
            chk("rsp_data", rdata, e_d);
            chk("rsp_error", 32'(rerr), 32'(e_e));
            chk("rsp_rd", 32'(rrd), 32'(e_rd));
            if (rvalid && rready && !flush) begin
                log_d.push_back(rdata);
                log_rd.push_back(rrd);
            end
            if (spur) spur_cnt++;
        end
    end

    function automatic logic [31:0] lgd(int i);
        return (i < log_d.size()) ? log_d[i] : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] lgr(int i);
        return (i < log_rd.size()) ? 32'(log_rd[i]) : 32'hDEADBEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int  l0;
    int  s0;
    bit  got;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset count", 32'(count), 0);
        chk("reset ready", 32'(irdy), 1);
        chk("reset valid", 32'(rvalid), 0);
        chk("reset tag", 32'(itag), 0);
        tick();

        // Out-of-order completion, in-order retire.
        l0 = log_d.size();
        rready = 1'b1;
        iv = 1'b1; ird = 5'd3; tick();
        ird = 5'd5; tick();
        ird = 5'd7; tick();
        iv = 1'b0;
        @(negedge clk);
        chk("t1 count3", 32'(count), 3);
        tick();
        cv = 1'b1; ctag = 2'd2; cdata = 32'h40000000;
        @(negedge clk);
        chk("t1 no rsp", 32'(rvalid), 0);
        tick();
        ctag = 2'd0; cdata = 32'h3F800000; tick();
        ctag = 2'd1; cdata = 32'hC0000000; tick();
        cv = 1'b0;
        repeat (4) tick();
        chk("t1 rd0", lgr(l0), 3);
        chk("t1 d0", lgd(l0), 32'h3F800000);
        chk("t1 rd1", lgr(l0 + 1), 5);
        chk("t1 d1", lgd(l0 + 1), 32'hC0000000);
        chk("t1 rd2", lgr(l0 + 2), 7);
        chk("t1 d2", lgd(l0 + 2), 32'h40000000);
        @(negedge clk);
        chk("t1 count0", 32'(count), 0);
        tick();

        // Reset mid-operation, then fill to full and wrap.
        rready = 1'b0;
        iv = 1'b1; ird = 5'd30; tick();
        iv = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t2 rst count", 32'(count), 0);
        tick();
        l0 = log_d.size();
        iv = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ird = 5'(i);
            tick();
        end
        ird = 5'd9;
        @(negedge clk);
        chk("t2 full ready", 32'(irdy), 0);
        chk("t2 full count", 32'(count), 4);
        tick();
        @(negedge clk);
        chk("t2 held count", 32'(count), 4);
        tick();
        cv = 1'b1; ctag = 2'd0; cdata = 32'h1; rready = 1'b1;
        tick();
        cv = 1'b0;
        got = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (irdy) begin
                got = 1;
                chk("t2 wrap tag", 32'(itag), 0);
                chk("t2 wrap count", 32'(count), 3);
                break;
            end
            tick();
        end
        if (!got) chk("t2 ready timeout", 0, 1);
        tick();
        iv = 1'b0;
        cv = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ctag = 2'(i);
            cdata = 32'(i + 1);
            tick();
        end
        cv = 1'b0;
        repeat (4) tick();
        chk("t2 rd0", lgr(l0), 1);
        chk("t2 d3", lgd(l0 + 3), 32'h4);
        chk("t2 rd4", lgr(l0 + 4), 9);
        chk("t2 d4", lgd(l0 + 4), 32'h5);

        // Spurious completions.
        flush = 1'b1; tick();
        flush = 1'b0;
        rready = 1'b0;
        iv = 1'b1; ird = 5'd10; tick();
        iv = 1'b0;
        s0 = spur_cnt;
        cv = 1'b1; ctag = 2'd2; cdata = 32'hAAAA; tick();
        ctag = 2'd0; cdata = 32'hA; tick();
        cdata = 32'hB; tick();
        cv = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("t3 spur pulses", 32'(spur_cnt - s0), 2);
        chk("t3 first data", rdata, 32'hA);
        tick();
        l0 = log_d.size();
        rready = 1'b1;
        tick(); tick();
        chk("t3 rd", lgr(l0), 10);
        chk("t3 d", lgd(l0), 32'hA);

        // Flush with simultaneous issue and completion.
        rready = 1'b1;
        iv = 1'b1; ird = 5'd11; tick();
        ird = 5'd12; tick();
        l0 = log_d.size();
        s0 = spur_cnt;
        flush = 1'b1; cv = 1'b1; ctag = 2'd0; cdata = 32'h7; ird = 5'd13;
        tick();
        flush = 1'b0; cv = 1'b0; iv = 1'b0;
        @(negedge clk);
        chk("t4 count", 32'(count), 0);
        chk("t4 valid", 32'(rvalid), 0);
        chk("t4 tag", 32'(itag), 0);
        tick();
        tick();
        chk("t4 no flush spur", 32'(spur_cnt - s0), 0);
        chk("t4 no retire", 32'(log_d.size() - l0), 0);
        cv = 1'b1; ctag = 2'd1; cdata = 32'h8; tick();
        cv = 1'b0;
        tick(); tick();
        chk("t4 stale spur", 32'(spur_cnt - s0), 1);

        // Backpressure holds an error response stable.
        rready = 1'b0;
        iv = 1'b1; ird = 5'd20; tick();
        iv = 1'b0;
        cv = 1'b1; ctag = 2'd0; cdata = 32'h55; cerr = 1'b1; tick();
        cv = 1'b0; cerr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5 hold valid", 32'(rvalid), 1);
            chk("t5 hold error", 32'(rerr), 1);
            tick();
        end
        l0 = log_d.size();
        rready = 1'b1; tick();
        @(negedge clk);
        chk("t5 count", 32'(count), 0);
        chk("t5 rd", lgr(l0), 20);
        tick();

        // Head completion latency.
        iv = 1'b1; ird = 5'd21; tick();
        iv = 1'b0;
        cv = 1'b1; ctag = 2'd1; cdata = 32'h12345678;
        @(negedge clk);
`ifdef RISCV_FPU_CMPL_BYPASS_EN
        chk("t6 byp valid", 32'(rvalid), 1);
        chk("t6 byp data", rdata, 32'h12345678);
`else
        chk("t6 valid early", 32'(rvalid), 0);
`endif
        tick();
        cv = 1'b0;
        @(negedge clk);
`ifdef RISCV_FPU_CMPL_BYPASS_EN
        chk("t6 byp count", 32'(count), 0);
        chk("t6 byp after", 32'(rvalid), 0);
`else
        chk("t6 valid", 32'(rvalid), 1);
        chk("t6 data", rdata, 32'h12345678);
        chk("t6 count1", 32'(count), 1);
`endif
        tick();
        @(negedge clk);
        chk("t6 count0", 32'(count), 0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
